uart_rx_ovs: RTL and testbench
==============================

// Module: uart_rx_ovs
// PURPOSE
// - Next-generation UART receiver. Oversamples rx with a runtime baud divisor and majority-votes each bit.
// - Runtime frame format: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
// - Completed frames go into an internal FIFO with per-entry error flags. Sticky overrun and break status.
// - Sits between the pad-side rx pin and the CSR/bus-side read port of the UART peripheral.
// PARAMETERS
// - OVS         16  ticks per bit; even, >= 8
// - FIFO_DEPTH  16  RX FIFO entries; power of two, >= 2
// - DIV_WIDTH   16  width of baud_div
// PORTS
// - clock          in   1                        system clock
// - reset          in   1                        sync, active-high
// - rx             in   1                        async serial input, idle high
// - baud_div       in   DIV_WIDTH                clocks per oversample tick minus 1
// - cfg_bits       in   2                        data bits: 0=5, 1=6, 2=7, 3=8
// - cfg_parity     in   2                        0=none, 1=even, 2=odd, 3=none
// - cfg_stop2      in   1                        1 = two stop bits
// - dout_valid     out  1                        FIFO non-empty
// - dout_ready     in   1                        pop when dout_valid & dout_ready
// - dout           out  8                        head data, LSB first on wire, unused MSBs 0
// - dout_perr      out  1                        head parity error
// - dout_ferr      out  1                        head framing error
// - fifo_count     out  $clog2(FIFO_DEPTH)+1     current occupancy
// - overrun        out  1                        sticky; frame dropped while FIFO full
// - overrun_clr    in   1                        clears overrun
// - break_det      out  1                        1-cycle pulse on break frame
// BEHAVIOUR
// - Reset: all outputs 0; FIFO empty; FSM IDLE; synchroniser flops reset to 1.
// - Reset mid-frame: frame discarded, no push.
// - rx passes a 2-FF synchroniser; rs = synced value. Rx-to-FSM latency is 2 clocks.
// - Tick counter runs 0..baud_div and pulses tick at baud_div.
//   - It is reset to 0 on start detection, which aligns the phase.
//   - baud_div=0 gives a tick every clock.
// - Sample counter sc counts 0..OVS-1 on ticks. Bit value = majority of rs at sc = OVS/2-1, OVS/2, OVS/2+1.
// - Bit decision is taken on the tick after sc = OVS/2+1.
// - FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
//   - IDLE: rs=0 -> START. cfg_bits, cfg_parity and cfg_stop2 are latched here; mid-frame cfg changes are ignored.
//   - START: voted 1 -> IDLE (false start, no push). Voted 0 -> DATA at sc wrap.
//   - DATA: shift N=5+cfg_bits bits LSB first; after bit N -> PARITY if parity enabled, else STOP1.
//   - PARITY: perr = (XOR data ^ pbit) != (odd ? 1 : 0).
//   - STOP1: ferr if voted 0. Then STOP2 if cfg_stop2, else push and go to IDLE.
//   - STOP2: ferr |= voted 0; push; IDLE.
// - Push happens at the stop-bit decision (mid-bit), so the next start edge can be caught immediately.
// - Break: data all 0, parity bit 0 (if enabled), and STOP1 voted 0.
//   - break_det pulses in the push cycle.
//   - Entry is pushed with dout=0, ferr=1.
// - FIFO is show-ahead: a pushed entry is visible on dout the next cycle, with dout_valid=1.
// - Full FIFO and push without pop: frame dropped, overrun set the next cycle.
// - Full FIFO and push with pop in the same cycle: push accepted, count unchanged.
// - Empty FIFO: pop ignored. Pop and push together when empty: the pop is ignored.
// - overrun_clr together with a new overrun event: set wins.
// - fifo_count never exceeds FIFO_DEPTH; FIFO pointers wrap modulo FIFO_DEPTH.
// STRUCTURE
// - uart_pkg: FSM state encoding, cfg_parity codes, cfg_bits codes, entry width (8+2).
// - Sub-module uart_sync_fifo (WIDTH, DEPTH): show-ahead, count output, full/empty, pop-when-empty ignored.
// - Top level holds the synchroniser, tick/sample counters, FSM, shift register, parity and status.
// TESTING
// - baud_div=3, OVS=16 (64 clk/bit), 8N1, send 0xA5 -> dout=0xA5, perr=0, ferr=0, fifo_count=1.
// - 7E2: send 0x35 with correct even parity -> dout=0x35, perr=0.
//   Resend 0x35 with the parity bit flipped -> perr=1.
// - 8N1, stop bit driven 0, data 0x00 -> break_det pulses 1 clk; entry dout=0x00, ferr=1.
// - Glitch: 0 held 2 ticks, then 1 -> no push, FSM back in IDLE, fifo_count=0.
// - dout_ready=0: send FIFO_DEPTH+1 bytes -> count=16, overrun=1, head = first byte.
//   Then overrun_clr -> overrun=0.
// - Assert reset at mid data bit 3 -> no entry; next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the oversampling UART receiver:
//               receiver FSM state encoding, cfg_parity and cfg_bits codes,
//               the FIFO entry layout, and small decode helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_t;

    // cfg_parity codes; code 3 is a second spelling of "no parity".
    localparam logic [1:0] PAR_NONE     = 2'd0;
    localparam logic [1:0] PAR_EVEN     = 2'd1;
    localparam logic [1:0] PAR_ODD      = 2'd2;
    localparam logic [1:0] PAR_NONE_ALT = 2'd3;

    // cfg_bits codes
    localparam logic [1:0] BITS_5 = 2'd0;
    localparam logic [1:0] BITS_6 = 2'd1;
    localparam logic [1:0] BITS_7 = 2'd2;
    localparam logic [1:0] BITS_8 = 2'd3;

    // FIFO entry: [9] parity error, [8] framing error, [7:0] data.
    localparam int ENTRY_W   = 10;
    localparam int ENT_PERR  = 9;
    localparam int ENT_FERR  = 8;

    function automatic logic [3:0] data_bits(input logic [1:0] code);
        logic [3:0] n;
        case (code)
            BITS_5:  n = 4'd5;
            BITS_6:  n = 4'd6;
            BITS_7:  n = 4'd7;
            BITS_8:  n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    function automatic logic parity_enabled(input logic [1:0] code);
        return (code != PAR_NONE) && (code != PAR_NONE_ALT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock show-ahead FIFO. The head entry is always
//               presented on rdata; a written entry is visible the cycle
//               after the write. Pop on empty is ignored; push on full is
//               accepted only if a pop happens in the same cycle.
// Ports       : clock, reset        - clock, sync active-high reset
//               push, wdata         - write request / data
//               pop                 - remove head entry
//               rdata               - head entry
//               count, full, empty  - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, the slot being popped this cycle is the one written.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ovs
// Description : Oversampling UART receiver with runtime baud divisor,
//               3-sample majority vote per bit, runtime frame format
//               (5-8 data bits, none/even/odd parity, 1/2 stop bits),
//               show-ahead RX FIFO with per-entry error flags, sticky
//               overrun and break-frame pulse.
// Ports       : clock, reset            - clock, sync active-high reset
//               rx                      - async serial input, idle high
//               baud_div                - clocks per oversample tick - 1
//               cfg_bits/parity/stop2   - frame format (latched per frame)
//               dout_valid/ready        - FIFO head handshake
//               dout, dout_perr/ferr    - FIFO head entry
//               fifo_count              - FIFO occupancy
//               overrun, overrun_clr    - sticky drop status and its clear
//               break_det               - 1-cycle pulse on break frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ovs #(
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic [1:0]                    cfg_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [7:0]                    dout,
    output logic                          dout_perr,
    output logic                          dout_ferr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          break_det
);

    import uart_pkg::*;

    localparam int SC_W = $clog2(OVS);
    localparam logic [SC_W-1:0] SC_S0   = SC_W'(OVS/2 - 1);
    localparam logic [SC_W-1:0] SC_S1   = SC_W'(OVS/2);
    localparam logic [SC_W-1:0] SC_S2   = SC_W'(OVS/2 + 1);
    localparam logic [SC_W-1:0] SC_DEC  = SC_W'(OVS/2 + 2);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVS - 1);

    // ---------------- synchroniser ----------------
    logic sync_meta;
    logic rs;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b1;
            rs        <= 1'b1;
        end else begin
            sync_meta <= rx;
            rs        <= sync_meta;
        end
    end

    // ---------------- tick / sample counters ----------------
    rx_state_t             state;
    rx_state_t             state_next;
    logic                  start_det;
    logic [DIV_WIDTH-1:0]  tick_cnt;
    logic                  tick;
    logic [SC_W-1:0]       sc;
    logic [2:0]            samp;
    logic                  vote;
    logic                  dec;
    logic                  wrap;

    assign start_det = (state == ST_IDLE) && !rs;
    // >= keeps the counter from running away if baud_div shrinks mid-count.
    assign tick      = (tick_cnt >= baud_div);
    assign dec       = tick && (sc == SC_DEC);
    assign wrap      = tick && (sc == SC_LAST);
    assign vote      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

    always_ff @(posedge clock) begin
        if (reset || start_det) begin
            tick_cnt <= '0;
            sc       <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            sc       <= (sc == SC_LAST) ? '0 : sc + SC_W'(1);
        end else begin
            tick_cnt <= tick_cnt + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            samp <= 3'b111;
        end else if (tick && (sc == SC_S0 || sc == SC_S1 || sc == SC_S2)) begin
            samp <= {samp[1:0], rs};
        end
    end

    // ---------------- per-frame datapath ----------------
    logic [3:0] nbits;
    logic       par_en;
    logic       par_odd;
    logic       stop2_l;
    logic [7:0] shreg;
    logic [3:0] bcnt;
    logic       perr_r;
    logic       ferr_r;
    logic       pzero_r;
    logic       brk_r;
    logic [7:0] data_al;
    logic       shreg_zero;

    // Bits enter at the MSB, so an N-bit frame ends up left-justified.
    assign data_al    = shreg >> (4'd8 - nbits);
    assign shreg_zero = (shreg == 8'h00);

    always_ff @(posedge clock) begin
        if (reset) begin
            nbits   <= 4'd8;
            par_en  <= 1'b0;
            par_odd <= 1'b0;
            stop2_l <= 1'b0;
            shreg   <= '0;
            bcnt    <= '0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            pzero_r <= 1'b1;
            brk_r   <= 1'b0;
        end else if (start_det) begin
            nbits   <= data_bits(cfg_bits);
            par_en  <= parity_enabled(cfg_parity);
            par_odd <= (cfg_parity == PAR_ODD);
            stop2_l <= cfg_stop2;
            shreg   <= '0;
            bcnt    <= '0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            pzero_r <= 1'b1;
            brk_r   <= 1'b0;
        end else begin
            if (state == ST_DATA && dec)  shreg <= {vote, shreg[7:1]};
            if (state == ST_DATA && wrap) bcnt  <= bcnt + 4'd1;
            if (state == ST_PARITY && dec) begin
                perr_r  <= ((^shreg) ^ vote) != par_odd;
                pzero_r <= ~vote;
            end
            if (state == ST_STOP1 && dec) begin
                ferr_r <= ~vote;
                brk_r  <= shreg_zero && pzero_r && ~vote;
            end
        end
    end

    // ---------------- FSM ----------------
    logic push_c;
    logic brk_c;
    logic ferr_c;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        push_c     = 1'b0;
        brk_c      = 1'b0;
        ferr_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rs) state_next = ST_START;
            end
            ST_START: begin
                if (dec && vote)  state_next = ST_IDLE;
                else if (wrap)    state_next = ST_DATA;
            end
            ST_DATA: begin
                if (wrap && bcnt == nbits - 4'd1)
                    state_next = par_en ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: begin
                if (wrap) state_next = ST_STOP1;
            end
            ST_STOP1: begin
                // Single stop bit: push mid-bit so the next start edge is not missed.
                if (dec && !stop2_l) begin
                    push_c     = 1'b1;
                    ferr_c     = ~vote;
                    brk_c      = shreg_zero && pzero_r && ~vote;
                    state_next = ST_IDLE;
                end else if (wrap && stop2_l) begin
                    state_next = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (dec) begin
                    push_c     = 1'b1;
                    ferr_c     = ferr_r | ~vote;
                    brk_c      = brk_r;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FIFO and status ----------------
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] head;

    // Gating with reset discards a frame whose push lands in a reset cycle.
    assign push      = push_c & ~reset;
    assign break_det = brk_c & ~reset;
    assign entry     = {perr_r, ferr_c, data_al};
    assign pop       = dout_valid & dout_ready;

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (entry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign dout_valid = ~empty;
    assign dout       = dout_valid ? head[7:0]      : 8'h00;
    assign dout_perr  = dout_valid & head[ENT_PERR];
    assign dout_ferr  = dout_valid & head[ENT_FERR];

    always_ff @(posedge clock) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (push && full && !pop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ovs
// Description : Self-checking bench for uart_rx_ovs. Frames are generated
//               as bit sequences on rx; expected FIFO entries, overrun and
//               break pulses come from a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ovs;

    localparam int OVS   = 16;
    localparam int DEPTH = 16;
    localparam int DW    = 16;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    rx;
    logic [DW-1:0]           baud_div;
    logic [1:0]              cfg_bits;
    logic [1:0]              cfg_parity;
    logic                    cfg_stop2;
    logic                    dout_valid;
    logic                    dout_ready;
    logic [7:0]              dout;
    logic                    dout_perr;
    logic                    dout_ferr;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overrun;
    logic                    overrun_clr;
    logic                    break_det;

    always #5 clock = ~clock;

    uart_rx_ovs #(
        .OVS        (OVS),
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .baud_div    (baud_div),
        .cfg_bits    (cfg_bits),
        .cfg_parity  (cfg_parity),
        .cfg_stop2   (cfg_stop2),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout        (dout),
        .dout_perr   (dout_perr),
        .dout_ferr   (dout_ferr),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .break_det   (break_det)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: expected FIFO contents {perr, ferr, data}.
    logic [9:0] exp_q[$];
    logic       exp_ovr = 1'b0;
    int         exp_brk_cnt = 0;

    int   brk_pulses = 0;
    int   brk_long   = 0;
    logic brk_prev   = 1'b0;

    always @(posedge clock) begin
        if (break_det) brk_pulses++;
        if (break_det && brk_prev) brk_long++;
        brk_prev = break_det;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bit_clks();
        return (int'(baud_div) + 1) * OVS;
    endfunction

    task automatic drive(input logic v, input int cyc);
        rx = v;
        repeat (cyc) @(negedge clock);
    endtask

    // par: cfg_parity code (0/3 none, 1 even, 2 odd); n: data bits 5..8.
    task automatic send_frame(input logic [7:0] d, input int n, input logic [1:0] par,
                              input logic s2, input logic flip,
                              input logic st1, input logic st2);
        int         bc;
        logic [7:0] dm;
        logic [7:0] mask;
        logic       pen;
        logic       p;
        logic       e_perr;
        logic       e_ferr;
        bc         = bit_clks();
        cfg_bits   = 2'(n - 5);
        cfg_parity = par;
        cfg_stop2  = s2;
        mask       = 8'((1 << n) - 1);
        dm         = d & mask;
        pen        = (par == 2'd1) || (par == 2'd2);
        p          = (^dm) ^ (par == 2'd2) ^ flip;
        drive(1'b0, bc);
        for (int i = 0; i < n; i++) drive(dm[i], bc);
        if (pen) drive(p, bc);
        drive(st1, bc);
        if (s2) drive(st2, bc);
        drive(1'b1, 2 * bc);
        e_ferr = !st1 || (s2 && !st2);
        e_perr = pen && (((^dm) ^ p) != (par == 2'd2));
        if ((dm == 8'h00) && (!pen || !p) && !st1) exp_brk_cnt++;
        if (exp_q.size() < DEPTH) exp_q.push_back({e_perr, e_ferr, dm});
        else                      exp_ovr = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 400 && !dout_valid; i++) @(negedge clock);
        check_eq({tag, " valid"}, 32'(dout_valid), 32'd1);
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] e;
        wait_valid(tag);
        if (exp_q.size() == 0) begin
            check_eq({tag, " unexpected entry"}, 32'(dout_valid), 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, " data"}, 32'(dout), 32'(e[7:0]));
            check_eq({tag, " perr"}, 32'(dout_perr), 32'(e[9]));
            check_eq({tag, " ferr"}, 32'(dout_ferr), 32'(e[8]));
        end
        dout_ready = 1'b1;
        @(negedge clock);
        dout_ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         brk0;
        logic [7:0] d;
        int         bc;
        rx          = 1'b1;
        reset       = 1'b1;
        baud_div    = 16'd3;
        cfg_bits    = 2'd3;
        cfg_parity  = 2'd0;
        cfg_stop2   = 1'b0;
        dout_ready  = 1'b0;
        overrun_clr = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check_eq("reset valid",   32'(dout_valid), 32'd0);
        check_eq("reset count",   32'(fifo_count), 32'd0);
        check_eq("reset overrun", 32'(overrun),    32'd0);
        check_eq("reset dout",    32'(dout),       32'd0);
        check_eq("reset break",   32'(brk_pulses), 32'd0);

        // 8N1 0xA5
        send_frame(8'hA5, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("A5 count", 32'(fifo_count), 32'd1);
        pop_check("A5");
        check_eq("A5 count after pop", 32'(fifo_count), 32'd0);

        // 7E2, correct then flipped parity
        send_frame(8'h35, 7, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        pop_check("7E2 good");
        send_frame(8'h35, 7, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        pop_check("7E2 flipped");

        // Break frame
        brk0 = brk_pulses;
        send_frame(8'h00, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("break pulses", 32'(brk_pulses - brk0), 32'(exp_brk_cnt));
        pop_check("break");

        // Glitch: low for two ticks only
        bc = bit_clks();
        drive(1'b0, 2 * (int'(baud_div) + 1));
        drive(1'b1, 3 * bc);
        check_eq("glitch count", 32'(fifo_count), 32'd0);
        check_eq("glitch valid", 32'(dout_valid), 32'd0);
        send_frame(8'h3C, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        pop_check("after glitch");

        // Reset in the middle of data bit 3
        d          = 8'h96;
        cfg_bits   = 2'd3;
        cfg_parity = 2'd0;
        cfg_stop2  = 1'b0;
        drive(1'b0, bc);
        for (int i = 0; i < 3; i++) drive(d[i], bc);
        drive(d[3], bc / 2);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 2 * bc);
        check_eq("midreset count", 32'(fifo_count), 32'd0);
        check_eq("midreset valid", 32'(dout_valid), 32'd0);
        send_frame(8'h5A, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        pop_check("5A after reset");

        // Overrun: DEPTH+1 frames with no reads
        baud_div = 16'd1;
        for (int i = 0; i <= DEPTH; i++)
            send_frame(8'($urandom), 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("full count",   32'(fifo_count), 32'(DEPTH));
        check_eq("overrun set",  32'(overrun),    32'(exp_ovr));
        check_eq("full head",    32'(dout),       32'(exp_q[0][7:0]));
        overrun_clr = 1'b1;
        @(negedge clock);
        overrun_clr = 1'b0;
        check_eq("overrun clr",  32'(overrun),    32'd0);
        for (int i = 0; i < DEPTH; i++) pop_check("drain");
        check_eq("drained count", 32'(fifo_count), 32'd0);

        // Randomised formats, errors and baud rates
        brk0        = brk_pulses;
        exp_brk_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            baud_div = 16'($urandom_range(0, 3));
            d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            send_frame(d, int'($urandom_range(5, 8)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) != 0),
                       ($urandom_range(0, 5) != 0));
            pop_check("random");
        end
        check_eq("random breaks",    32'(brk_pulses - brk0), 32'(exp_brk_cnt));
        check_eq("break pulse width", 32'(brk_long),         32'd0);
        check_eq("final count",       32'(fifo_count),       32'd0);
        check_eq("final overrun",     32'(overrun),          32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
